// File: rtl/peridot_ft245_txarb_if.sv
// Bundle of the two requester byte streams, the phy TX handshake and
// the arbiter status outputs.
interface peridot_ft245_txarb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_eop;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_eop;
  logic       req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] grant;
  logic       busy;

  modport master (
    output req0_valid, req0_data, req0_eop,
    output req1_valid, req1_data, req1_eop,
    output tx_ready,
    input  req0_ready, req1_ready, tx_valid, tx_data, grant, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_eop,
    input  req1_valid, req1_data, req1_eop,
    input  tx_ready,
    output req0_ready, req1_ready, tx_valid, tx_data, grant, busy
  );
endinterface

// File: rtl/peridot_ft245_txarb.sv
// Two-requester round-robin arbiter feeding the FT245 TX sink; each grant emits
// a header byte followed by up to MAX_BURST payload bytes.
module peridot_ft245_txarb #(
  parameter int         MAX_BURST   = 64,
  parameter logic [7:0] HEADER_BASE = 8'h7C
) (
  input  logic                  clock_sig,
  input  logic                  reset_sig,
  peridot_ft245_txarb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t     state_r, state_s;
  logic [1:0] grant_r, grant_s;
  logic       ptr_r, ptr_s;
  logic [7:0] cnt_r, cnt_s;

  logic       gidx_s;
  logic       g_valid_s;
  logic [7:0] g_data_s;
  logic       g_eop_s;
  logic       g_ready_s;
  logic       win_s;
  logic       tx_valid_s;
  logic [7:0] tx_data_s;
  logic       req0_ready_s;
  logic       req1_ready_s;

  // Mux the currently granted requester's stream
  always_comb begin
    gidx_s    = grant_r[1];
    g_valid_s = 1'b0;
    g_data_s  = 8'h00;
    g_eop_s   = 1'b0;
    if (gidx_s) begin
      g_valid_s = bus.req1_valid;
      g_data_s  = bus.req1_data;
      g_eop_s   = bus.req1_eop;
    end else begin
      g_valid_s = bus.req0_valid;
      g_data_s  = bus.req0_data;
      g_eop_s   = bus.req0_eop;
    end
  end

  // Next-state, arbitration and handshake outputs
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    ptr_s      = ptr_r;
    cnt_s      = cnt_r;
    win_s      = 1'b0;
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    g_ready_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // ptr_r names the requester preferred when both contend
        if (bus.req0_valid && bus.req1_valid) begin
          win_s = ptr_r;
        end else if (bus.req0_valid) begin
          win_s = 1'b0;
        end else begin
          win_s = 1'b1;
        end
        if (bus.req0_valid || bus.req1_valid) begin
          grant_s = win_s ? 2'b10 : 2'b01;
          state_s = ST_HEADER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        tx_valid_s = 1'b1;
        tx_data_s  = HEADER_BASE + {7'd0, gidx_s};
        if (bus.tx_ready) begin
          state_s = ST_DATA;
          cnt_s   = 8'd0;
        end else begin
          state_s = ST_HEADER;
        end
      end
      ST_DATA: begin
        tx_valid_s = g_valid_s;
        tx_data_s  = g_valid_s ? g_data_s : 8'h00;
        g_ready_s  = bus.tx_ready & g_valid_s;
        if (g_ready_s) begin
          cnt_s = cnt_r + 8'd1;
          // A burst-limited cut leaves the remainder queued at the source
          if (g_eop_s || (cnt_r == LAST_CNT)) begin
            state_s = ST_IDLE;
            grant_s = 2'b00;
            ptr_s   = ~gidx_s;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // Route the granted ready back to its owner only
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (gidx_s) begin
      req1_ready_s = g_ready_s;
    end else begin
      req0_ready_s = g_ready_s;
    end
  end

  // State, grant, priority pointer and burst counter registers
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_r <= ST_IDLE;
      grant_r <= 2'b00;
      ptr_r   <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.tx_valid   = tx_valid_s;
  assign bus.tx_data    = tx_data_s;
  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.grant      = grant_r;
  assign bus.busy       = (state_r != ST_IDLE);

endmodule
